coinc_interval_timer: RTL and testbench
=======================================

Name: coinc_interval_timer

Overview:
- Parametrised successor to the single-channel muon-lifetime start/stop timer.
- N_CH discriminator inputs; runtime-programmable start-coincidence, veto and stop masks.
- Prescaled interval counter of width CNT_W; qualified results go into a FIFO with a valid/ready drain for the serial sender.
- Runtime-selectable monitor mux drives the scope/LEMO output.

Parameters:
- N_CH, 3, number of discriminator input channels (2..8)
- CNT_W, 8, interval counter width in bits
- PRESCALE, 4, clk cycles per count increment (>=1)
- FIFO_DEPTH, 8, result FIFO entries (power of 2, >=2)
- HOLDOFF_CYCLES, 16, dead time after each stop or overflow (>=0)

Ports:
- clk  in  1  system clock, sole clock domain
- reset  in  1  asynchronous, active-high reset
- sig_in  in  N_CH  discriminator inputs, already synchronous to clk
- start_req_mask  in  N_CH  channels that must all be high to start
- start_veto_mask  in  N_CH  any masked channel high blocks start
- stop_mask  in  N_CH  any masked channel high stops counting
- min_count  in  CNT_W  results below this value are discarded
- mon_sel  in  4  monitor mux select
- mon_out  out  1  monitor output, registered
- counting  out  1  high while in COUNT
- result_data  out  CNT_W  FIFO head
- result_valid  out  1  FIFO not empty
- result_ready  in  1  consumer accepts head
- drop_cnt  out  8  saturating count of results lost to a full FIFO
- ovf_cnt  out  8  saturating count of overflows

Behaviour:
- Reset (async assert, sync release): state IDLE, count=0, prescale counter=0, FIFO empty, result_valid=0, counting=0, mon_out=0, drop_cnt=0, ovf_cnt=0, sig_q=0.
- sig_q registers sig_in, adding 1 cycle of latency. All decisions use sig_q.
- start = (start_req_mask!=0) & &(sig_q | ~start_req_mask) & ~|(sig_q & start_veto_mask).
- stop = |(sig_q & stop_mask).
- IDLE: when start, go to COUNT with count=1 and prescale=0. counting rises on the next cycle.
- COUNT:
  - prescale increments each cycle and wraps at PRESCALE-1; count increments on the wrap.
  - Stop has priority over increment. On stop with count < 2^CNT_W-1: push count if count >= min_count, otherwise discard; go to HOLDOFF.
  - If count reaches 2^CNT_W-1 (stop present or not): no push, ovf_cnt++, go to HOLDOFF.
  - start is ignored while in COUNT.
- HOLDOFF: wait HOLDOFF_CYCLES cycles, then IDLE. With HOLDOFF_CYCLES=0, go to IDLE on the next cycle. start is ignored.
- FIFO:
  - Pop when result_valid & result_ready. Push lands at the tail, visible on result_data/result_valid the cycle after push.
  - Push while full with no pop: drop the value, drop_cnt++.
  - Push while full with a simultaneous pop: both succeed, no drop.
  - Pop while empty: no effect.
- Counters: drop_cnt and ovf_cnt saturate at 255 and never wrap.
- mon_out (registered):
  - sel 0..N_CH-1: sig_q[sel]
  - sel 8: start
  - sel 9: stop
  - sel 10: counting
  - sel 11: result_valid
  - any other sel: 0
- Reset mid-COUNT: the event in progress is abandoned and nothing is pushed.
- Mask inputs are quasi-static. A mask change during COUNT takes effect the next cycle.

Optional Feature:
- TIMER_SELFTEST_EN defined: adds input selftest_en (1 bit).
  - When high, an internal 16-bit LFSR-timed pulser forces a start once every 2^16 cycles.
  - It forces a stop (100 + LFSR[5:0]) clk cycles later, independent of sig_in.
  - mon_sel=12 outputs the pulser start strobe.
- Undefined: no port and no logic; mon_sel=12 outputs 0.

Decomposition:
- Shared package timer_pkg: state enum (IDLE, COUNT, HOLDOFF), mon_sel encodings, saturating-increment function.
- One sub-module, sync_fifo (parametrised width/depth, registered head, full/empty flags), reusable by other serial-reporting blocks.
- Start/stop/mask logic and the FSM stay in the top module.

Test Plan:
- Setup: N_CH=3, PRESCALE=4, start_req=3'b011, veto=3'b100, stop=3'b100, min_count=3. Pulse ch0&ch1, then ch2 after 40 cycles -> one result of 11, result_valid high.
- Veto: ch0&ch1&ch2 high together -> no start, counting stays 0, FIFO empty.
- Short interval: stop 6 cycles after start -> count=2 < min_count, nothing pushed, HOLDOFF still occurs. A start during the 16 HOLDOFF cycles is ignored.
- Overflow: start with no stop -> after 254×4 cycles ovf_cnt=1, no push, state returns to IDLE after holdoff.
- FIFO full: hold result_ready=0, produce 10 valid events -> 8 stored, drop_cnt=2. Drain with result_ready=1 -> data in order.
- Reset mid-COUNT: assert reset asynchronously -> counting=0 immediately, FIFO empty, drop_cnt=0, ovf_cnt=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the coincidence interval timer and related serial-reporting blocks.
// Contents: FSM state encodings, monitor-mux select codes, and a saturating 8-bit increment.
package timer_pkg;

    localparam int unsigned STAT_W = 8;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COUNT   = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    // Monitor mux selects; codes 0..7 select a registered discriminator channel
    localparam logic [3:0] MON_START    = 4'd8;
    localparam logic [3:0] MON_STOP     = 4'd9;
    localparam logic [3:0] MON_COUNTING = 4'd10;
    localparam logic [3:0] MON_VALID    = 4'd11;
    localparam logic [3:0] MON_PULSER   = 4'd12;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/coinc_interval_timer_if.sv
// Result drain bus: FIFO head with a valid/ready handshake toward the serial sender.
// Ports: result_data (CNT_W) and result_valid from the producer, result_ready from the consumer.
interface coinc_interval_timer_if #(
    parameter int unsigned CNT_W = 8
);
    logic [CNT_W-1:0] result_data;
    logic             result_valid;
    logic             result_ready;

    modport master (output result_data, output result_valid, input result_ready);
    modport slave  (input result_data, input result_valid, output result_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word and registered valid/full flags.
// Ports: clk, reset (async, active-high), push_i/wdata_i, pop_i, rdata_o (head), valid_o, full_o.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic             full_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d, full_q, full_d;
    logic             do_push, do_pop;

    // Pointer/occupancy update and look-ahead of the next head word
    always_comb begin
        do_pop   = pop_i && valid_q;
        do_push  = push_i && (!full_q || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d    = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
        // The slot about to become head may be the one being written this cycle
        head_d   = (do_push && (wr_ptr_q == rd_ptr_d)) ? wdata_i : mem_q[rd_ptr_d];
        valid_d  = (occ_d != '0);
        full_d   = (occ_d == OCC_W'(DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    // Storage array carries no reset; contents are qualified by occupancy
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = head_q;
    assign valid_o = valid_q;
    assign full_o  = full_q;

endmodule

// File: rtl/coinc_interval_timer.sv
// Coincidence start/stop interval timer: masked start coincidence with veto, masked stop,
// prescaled interval counter, dead-time after each event, and a result FIFO drained over res_if.
// Ports: clk, reset (async, active-high), sig_in, start_req_mask, start_veto_mask, stop_mask,
//        min_count, mon_sel, mon_out, counting, res_if (master), drop_cnt, ovf_cnt.
// Build option TIMER_SELFTEST_EN adds input selftest_en and an internal LFSR-timed pulser
// that forces a start every 2^16 cycles and a stop 100..163 cycles later.
module coinc_interval_timer
    import timer_pkg::*;
#(
    parameter int unsigned N_CH           = 3,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned PRESCALE       = 4,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned HOLDOFF_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       sig_in,
    input  logic [N_CH-1:0]       start_req_mask,
    input  logic [N_CH-1:0]       start_veto_mask,
    input  logic [N_CH-1:0]       stop_mask,
    input  logic [CNT_W-1:0]      min_count,
    input  logic [3:0]            mon_sel,
`ifdef TIMER_SELFTEST_EN
    input  logic                  selftest_en,
`endif
    output logic                  mon_out,
    output logic                  counting,
    coinc_interval_timer_if.master res_if,
    output logic [STAT_W-1:0]     drop_cnt,
    output logic [STAT_W-1:0]     ovf_cnt
);
    localparam int unsigned PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N_CH-1:0]   sig_q;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              counting_q, counting_d;
    logic              mon_q, mon_d;
    logic [STAT_W-1:0] drop_q, drop_d, ovf_q, ovf_d;
    logic              start_c, stop_c, start_eff_c, stop_eff_c, pulse_c;
    logic              push_c, pop_c, fifo_full;
    logic [7:0]        sig_pad;

    // Coincidence decisions on the registered inputs
    assign start_c = (|start_req_mask) & (&(sig_q | ~start_req_mask)) & ~|(sig_q & start_veto_mask);
    assign stop_c  = |(sig_q & stop_mask);

`ifdef TIMER_SELFTEST_EN
    logic [15:0] lfsr_q, lfsr_d, per_q, per_d;
    logic [7:0]  dly_q, dly_d;
    logic        run_q, run_d, st_stop_c;

    // Self-test pulser: periodic forced start, LFSR-randomised forced stop
    always_comb begin
        lfsr_d    = lfsr_q;
        per_d     = per_q;
        dly_d     = dly_q;
        run_d     = run_q;
        pulse_c   = 1'b0;
        st_stop_c = 1'b0;
        if (selftest_en) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            per_d  = per_q + 16'd1;
            if (per_q == 16'hFFFF) begin
                pulse_c = 1'b1;
                dly_d   = 8'd100 + 8'(lfsr_q[5:0]);
                run_d   = 1'b1;
            end
        end
        if (run_q && !pulse_c) begin
            if (dly_q == 8'd1) begin
                st_stop_c = 1'b1;
                run_d     = 1'b0;
            end else begin
                dly_d = dly_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'h0001;
            per_q  <= '0;
            dly_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            per_q  <= per_d;
            dly_q  <= dly_d;
            run_q  <= run_d;
        end
    end

    assign start_eff_c = start_c | pulse_c;
    assign stop_eff_c  = stop_c | st_stop_c;
`else
    assign pulse_c     = 1'b0;
    assign start_eff_c = start_c;
    assign stop_eff_c  = stop_c;
`endif

    // Interval FSM; overflow outranks stop, stop outranks increment
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ps_d    = ps_q;
        hold_d  = hold_q;
        ovf_d   = ovf_q;
        push_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_eff_c) begin
                    state_d = ST_COUNT;
                    count_d = CNT_W'(1);
                    ps_d    = '0;
                end
            end
            ST_COUNT: begin
                if (count_q == CNT_MAX) begin
                    ovf_d   = sat_inc(ovf_q);
                    state_d = ST_HOLDOFF;
                    hold_d  = '0;
                end else if (stop_eff_c) begin
                    push_c  = (count_q >= min_count);
                    state_d = ST_HOLDOFF;
                    hold_d  = '0;
                end else if (ps_q == PS_W'(PRESCALE - 1)) begin
                    ps_d    = '0;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    ps_d    = ps_q + PS_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if ((HOLDOFF_CYCLES <= 1) || (hold_q == HOLD_W'(int'(HOLDOFF_CYCLES) - 1))) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Drop accounting and registered status/monitor outputs
    always_comb begin
        pop_c      = res_if.result_valid & res_if.result_ready;
        drop_d     = (push_c && fifo_full && !pop_c) ? sat_inc(drop_q) : drop_q;
        counting_d = (state_d == ST_COUNT);
        sig_pad    = 8'(sig_q);
        mon_d      = 1'b0;
        if (!mon_sel[3]) begin
            mon_d = sig_pad[mon_sel[2:0]];
        end else begin
            case (mon_sel)
                MON_START:    mon_d = start_eff_c;
                MON_STOP:     mon_d = stop_eff_c;
                MON_COUNTING: mon_d = counting_q;
                MON_VALID:    mon_d = res_if.result_valid;
                MON_PULSER:   mon_d = pulse_c;
                default:      mon_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q      <= '0;
            state_q    <= ST_IDLE;
            count_q    <= '0;
            ps_q       <= '0;
            hold_q     <= '0;
            counting_q <= 1'b0;
            mon_q      <= 1'b0;
            drop_q     <= '0;
            ovf_q      <= '0;
        end else begin
            sig_q      <= sig_in;
            state_q    <= state_d;
            count_q    <= count_d;
            ps_q       <= ps_d;
            hold_q     <= hold_d;
            counting_q <= counting_d;
            mon_q      <= mon_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (CNT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .wdata_i (count_q),
        .pop_i   (res_if.result_ready),
        .rdata_o (res_if.result_data),
        .valid_o (res_if.result_valid),
        .full_o  (fifo_full)
    );

    assign mon_out  = mon_q;
    assign counting = counting_q;
    assign drop_cnt = drop_q;
    assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_coinc_interval_timer.sv
// Directed bench for coinc_interval_timer with default parameters (N_CH=3, PRESCALE=4,
// CNT_W=8, FIFO_DEPTH=8, HOLDOFF_CYCLES=16). Inputs change 1 time unit after a rising edge
// and outputs are sampled at the same point, so an input driven there is captured on the next edge.
module tb_coinc_interval_timer;

    logic       clk;
    logic       reset;
    logic [2:0] sig_in;
    logic [2:0] start_req_mask;
    logic [2:0] start_veto_mask;
    logic [2:0] stop_mask;
    logic [7:0] min_count;
    logic [3:0] mon_sel;
    logic       mon_out;
    logic       counting;
    logic [7:0] drop_cnt;
    logic [7:0] ovf_cnt;

    int total = 0;
    int bad   = 0;

    coinc_interval_timer_if #(.CNT_W(8)) res_if ();

    coinc_interval_timer dut (
        .clk             (clk),
        .reset           (reset),
        .sig_in          (sig_in),
        .start_req_mask  (start_req_mask),
        .start_veto_mask (start_veto_mask),
        .stop_mask       (stop_mask),
        .min_count       (min_count),
        .mon_sel         (mon_sel),
        .mon_out         (mon_out),
        .counting        (counting),
        .res_if          (res_if),
        .drop_cnt        (drop_cnt),
        .ovf_cnt         (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Start coincidence captured on edge E0, stop channel captured on edge E_d.
    // The count latched at the stop is 1 + (d-1)/4.
    task automatic do_event(input int d);
        sig_in = 3'b011;
        tick(1);
        sig_in = 3'b000;
        tick(d - 1);
        sig_in = 3'b100;
        tick(1);
        sig_in = 3'b000;
    endtask

    initial begin
        clk                 = 1'b0;
        reset               = 1'b1;
        sig_in              = 3'b000;
        start_req_mask      = 3'b011;
        start_veto_mask     = 3'b100;
        stop_mask           = 3'b100;
        min_count           = 8'd3;
        mon_sel             = 4'd0;
        res_if.result_ready = 1'b0;

        #12;
        chk("rst_counting", 32'(counting), 32'd0);
        chk("rst_valid", 32'(res_if.result_valid), 32'd0);
        chk("rst_mon", 32'(mon_out), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf_cnt), 32'd0);
        reset = 1'b0;
        tick(2);

        // Basic interval: ch0&ch1 start, ch2 stop 41 edges later -> 11
        sig_in = 3'b011;
        tick(1);
        chk("start_lat0", 32'(counting), 32'd0);
        sig_in = 3'b000;
        tick(1);
        chk("start_lat1", 32'(counting), 32'd1);
        tick(39);
        sig_in = 3'b100;
        tick(1);
        sig_in = 3'b000;
        chk("pre_push_valid", 32'(res_if.result_valid), 32'd0);
        tick(1);
        chk("basic_valid", 32'(res_if.result_valid), 32'd1);
        chk("basic_data", 32'(res_if.result_data), 32'd11);
        chk("basic_counting", 32'(counting), 32'd0);
        res_if.result_ready = 1'b1;
        tick(1);
        res_if.result_ready = 1'b0;
        chk("basic_drained", 32'(res_if.result_valid), 32'd0);
        tick(20);

        // Veto: all three channels together must not start
        sig_in = 3'b111;
        tick(1);
        sig_in = 3'b000;
        tick(3);
        chk("veto_counting", 32'(counting), 32'd0);
        chk("veto_valid", 32'(res_if.result_valid), 32'd0);

        // Monitor mux
        sig_in  = 3'b001;
        mon_sel = 4'd0;
        tick(2);
        chk("mon_ch0", 32'(mon_out), 32'd1);
        mon_sel = 4'd1;
        tick(1);
        chk("mon_ch1", 32'(mon_out), 32'd0);
        sig_in  = 3'b100;
        mon_sel = 4'd9;
        tick(2);
        chk("mon_stop", 32'(mon_out), 32'd1);
        mon_sel = 4'd2;
        tick(1);
        chk("mon_ch2", 32'(mon_out), 32'd1);
        sig_in  = 3'b111;
        mon_sel = 4'd3;
        tick(2);
        chk("mon_sel_oob", 32'(mon_out), 32'd0);
        mon_sel = 4'd12;
        tick(1);
        chk("mon_pulser_off", 32'(mon_out), 32'd0);
        sig_in  = 3'b000;
        mon_sel = 4'd10;
        tick(3);
        chk("mon_counting_idle", 32'(mon_out), 32'd0);

        // Short interval: count 2 < min_count, discarded; start during holdoff ignored
        do_event(6);
        tick(3);
        sig_in = 3'b011;
        tick(1);
        sig_in = 3'b000;
        tick(2);
        chk("holdoff_ignore", 32'(counting), 32'd0);
        chk("short_valid", 32'(res_if.result_valid), 32'd0);
        tick(20);
        chk("short_after", 32'(counting), 32'd0);

        // Overflow: count reaches 255 at edge E1017, HOLDOFF on E1018
        sig_in = 3'b011;
        tick(1);
        sig_in = 3'b000;
        tick(1010);
        chk("ovf_still_counting", 32'(counting), 32'd1);
        chk("mon_counting_busy", 32'(mon_out), 32'd1);
        chk("ovf_before", 32'(ovf_cnt), 32'd0);
        tick(10);
        chk("ovf_cnt", 32'(ovf_cnt), 32'd1);
        chk("ovf_counting", 32'(counting), 32'd0);
        chk("ovf_no_push", 32'(res_if.result_valid), 32'd0);
        tick(20);

        // FIFO full: counts 3..12 with no drain, last two dropped
        for (int k = 3; k <= 12; k++) begin
            do_event(4 * k - 3);
            tick(20);
        end
        chk("full_drop", 32'(drop_cnt), 32'd2);
        chk("full_valid", 32'(res_if.result_valid), 32'd1);
        res_if.result_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", 32'(res_if.result_data), 32'(3 + i));
            tick(1);
        end
        res_if.result_ready = 1'b0;
        chk("drain_empty", 32'(res_if.result_valid), 32'd0);

        // Reset mid-COUNT with a queued result and nonzero counters
        do_event(17);
        tick(20);
        chk("pre_rst_valid", 32'(res_if.result_valid), 32'd1);
        chk("pre_rst_data", 32'(res_if.result_data), 32'd5);
        sig_in = 3'b011;
        tick(1);
        sig_in = 3'b000;
        tick(5);
        chk("pre_rst_counting", 32'(counting), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_counting", 32'(counting), 32'd0);
        chk("arst_valid", 32'(res_if.result_valid), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        chk("arst_ovf", 32'(ovf_cnt), 32'd0);
        #3;
        reset  = 1'b0;
        sig_in = 3'b100;
        tick(3);
        sig_in = 3'b000;
        chk("post_rst_counting", 32'(counting), 32'd0);
        chk("post_rst_valid", 32'(res_if.result_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
